// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO pair.
// MULT/MULTU/DIV/DIVU run for a fixed cycle count; MTHI/MTLO write in one cycle.
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        opa, opb;
  logic               is_div, is_unsigned;
  logic               accept_md, write_hi, write_lo, commit, last_cycle;

  logic [63:0]        prod;
  logic               neg_a, neg_b, div_zero;
  logic [31:0]        mag_a, mag_b, q_mag, r_mag, quo, rem;

  assign busy       = (state == RUN);
  assign last_cycle = (cnt == CNT_W'(1));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (accept_md)  state_next = RUN;
      RUN:     if (last_cycle) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: requests are only honoured while idle, so start during RUN is dropped.
  always_comb begin
    accept_md = 1'b0;
    write_hi  = 1'b0;
    write_lo  = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept_md = (op <= OP_DIVU);
        write_hi  = (op == OP_MTHI);
        write_lo  = (op == OP_MTLO);
      end
      RUN:     commit = last_cycle;
      default: ;
    endcase
  end

  // Sign/zero extension to 64 bits lets a single multiplier serve both MULT and MULTU.
  always_comb begin
    prod = {{32{~is_unsigned & opa[31]}}, opa} * {{32{~is_unsigned & opb[31]}}, opb};
  end

  // Divide on magnitudes; the -2^31 / -1 case falls out as 0x80000000 with no special case.
  always_comb begin
    neg_a    = ~is_unsigned & opa[31];
    neg_b    = ~is_unsigned & opb[31];
    div_zero = (opb == 32'd0);
    mag_a    = neg_a ? -opa : opa;
    mag_b    = neg_b ? -opb : opb;
    q_mag    = 32'd0;
    r_mag    = 32'd0;
    if (!div_zero) begin
      q_mag = mag_a / mag_b;
      r_mag = mag_a % mag_b;
    end
    quo = (neg_a ^ neg_b) ? -q_mag : q_mag;
    rem = neg_a ? -r_mag : r_mag;
  end

  // Datapath: counter, captured operands and HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      opa         <= '0;
      opb         <= '0;
      is_div      <= 1'b0;
      is_unsigned <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      if (accept_md) begin
        cnt         <= op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        opa         <= rs_data;
        opb         <= rt_data;
        is_div      <= op[1];
        is_unsigned <= op[0];
      end else if (state == RUN) begin
        cnt <= cnt - CNT_W'(1);
      end

      if (write_hi) hi <= rs_data;
      if (write_lo) lo <= rs_data;

      // A zero divisor still spends the full busy time but leaves HI/LO alone.
      if (commit) begin
        if (!is_div) begin
          hi <= prod[63:32];
          lo <= prod[31:0];
        end else if (!div_zero) begin
          hi <= rem;
          lo <= quo;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: expected HI/LO results go into a scoreboard queue
// at issue time and are popped and compared when busy drops.
module tb_mdu_hilo;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    string       tag;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } sb_entry_t;

  sb_entry_t   sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] hi_m, lo_m;

  mdu_hilo #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // mode 0: plain, 1: scramble operands while busy, 2: start MTLO while busy
  task automatic run_muldiv(input string tag, input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] b, input int n, input logic [31:0] eh,
                            input logic [31:0] el, input int mode);
    int        cyc;
    sb_entry_t e;
    sb.push_back('{tag: tag, exp_hi: eh, exp_lo: el});
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    tick();
    start = 1'b0;
    cyc   = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      check({tag, " hold hi"}, {32'd0, hi}, {32'd0, hi_m});
      check({tag, " hold lo"}, {32'd0, lo}, {32'd0, lo_m});
      if (mode == 1) begin
        rs_data = $urandom;
        rt_data = $urandom;
      end
      if (mode == 2) begin
        start   = (cyc == 2);
        op      = 3'd5;
        rs_data = 32'hDEADBEEF;
      end
      tick();
    end
    start = 1'b0;
    check({tag, " busy cycles"}, 64'(cyc), 64'(n));
    e = sb.pop_front();
    check({e.tag, " hi"}, {32'd0, hi}, {32'd0, e.exp_hi});
    check({e.tag, " lo"}, {32'd0, lo}, {32'd0, e.exp_lo});
    hi_m = e.exp_hi;
    lo_m = e.exp_lo;
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    op      = 3'd0;
    rs_data = '0;
    rt_data = '0;
    hi_m    = '0;
    lo_m    = '0;
    repeat (2) tick();
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset hi", {32'd0, hi}, 64'd0);
    check("reset lo", {32'd0, lo}, 64'd0);
    reset = 1'b0;
    tick();

    run_muldiv("mult -2*3", 3'd0, 32'hFFFFFFFE, 32'd3, MULT_N, 32'hFFFFFFFF, 32'hFFFFFFFA, 0);
    run_muldiv("multu max*max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, MULT_N,
               32'hFFFFFFFE, 32'h00000001, 1);
    run_muldiv("div -7/2", 3'd2, 32'hFFFFFFF9, 32'd2, DIV_N, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_muldiv("divu 7/0", 3'd3, 32'd7, 32'd0, DIV_N, hi_m, lo_m, 0);
    run_muldiv("div min/-1", 3'd2, 32'h80000000, 32'hFFFFFFFF, DIV_N,
               32'h00000000, 32'h80000000, 2);
    run_muldiv("div 7/-2", 3'd2, 32'd7, 32'hFFFFFFFE, DIV_N, 32'h00000001, 32'hFFFFFFFD, 0);
    run_muldiv("divu 100/7", 3'd3, 32'd100, 32'd7, DIV_N, 32'd2, 32'd14, 0);

    // MTHI then MTLO on consecutive cycles
    start   = 1'b1;
    op      = 3'd4;
    rs_data = 32'h12345678;
    tick();
    check("mthi hi", {32'd0, hi}, 64'h12345678);
    check("mthi lo kept", {32'd0, lo}, {32'd0, lo_m});
    check("mthi busy", {63'd0, busy}, 64'd0);
    op      = 3'd5;
    rs_data = 32'h9ABCDEF0;
    tick();
    check("mtlo lo", {32'd0, lo}, 64'h9ABCDEF0);
    check("mtlo hi kept", {32'd0, hi}, 64'h12345678);
    check("mtlo busy", {63'd0, busy}, 64'd0);
    hi_m = 32'h12345678;
    lo_m = 32'h9ABCDEF0;

    // op 6 is a no-op
    op      = 3'd6;
    rs_data = 32'h55555555;
    tick();
    start = 1'b0;
    check("nop busy", {63'd0, busy}, 64'd0);
    check("nop hi", {32'd0, hi}, {32'd0, hi_m});
    check("nop lo", {32'd0, lo}, {32'd0, lo_m});

    // DIV aborted by reset on cycle 4 of RUN; a start in the reset cycle is ignored
    start   = 1'b1;
    op      = 3'd2;
    rs_data = 32'd1000;
    rt_data = 32'd3;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("abort busy before reset", {63'd0, busy}, 64'd1);
    reset   = 1'b1;
    start   = 1'b1;
    op      = 3'd4;
    rs_data = 32'hAAAA5555;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort hi", {32'd0, hi}, 64'd0);
    check("abort lo", {32'd0, lo}, 64'd0);
    hi_m = '0;
    lo_m = '0;
    run_muldiv("mult after reset", 3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, MULT_N,
               32'h3FFFFFFF, 32'h00000001, 0);
    check("scoreboard empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Multi-cycle multiply/divide unit with the architectural HI/LO register pair. It sits downstream of the register file and consumes the two read operands (rs, rt) in the EX stage. It executes MULT/MULTU/DIV/DIVU over a fixed number of cycles, and handles MTHI/MTLO in a single cycle. HI/LO are exposed continuously for MFHI/MFLO, and a busy flag feeds the pipeline stall logic.

## Interface
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  operation request, sampled on rising clk edge
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
- rs_data  in  32  operand A / dividend / MTHI-MTLO source
- rt_data  in  32  operand B / divisor
- busy  out  1  registered; high while a mult/div is in flight
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- Reset: hi=0, lo=0, busy=0, cycle counter=0, pending result discarded; reset has priority over all inputs.
- Accept rule: start=1 and busy=0 at an edge. start while busy=1 is ignored entirely; no queuing.
- MULT: {hi,lo} = signed(rs) × signed(rt), 64-bit product.
- MULTU: same as MULT, unsigned.
- DIV:
  - lo = quotient truncated toward zero; hi = remainder, sign of dividend.
  - 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU: unsigned quotient/remainder.
- Divide by zero (rt=0, DIV or DIVU): still runs DIV_CYCLES with busy high; hi/lo left unchanged at completion.
- Operands are captured at accept; later changes on rs_data/rt_data do not affect the result.
- MTHI/MTLO: write hi (resp. lo) ← rs_data at the accept edge; busy stays 0; the other register is untouched.
- op 6/7 with start=1: no effect.
- State machine:
  - IDLE: on accepted mult/div, load counter with MULT_CYCLES or DIV_CYCLES and go to RUN.
  - RUN: decrement counter each cycle; at the edge where counter reaches 0, commit hi/lo and return to IDLE.
- Stall contract for the pipeline control:
  - MFHI/MFLO/MTHI/MTLO/mult/div in ID must stall while (busy | (start & op≤3)).
  - This unit does not itself stall or detect hazards.

## Timing
- Accept at edge E0 → busy=1 from E0 to edge E_N, N = MULT_CYCLES or DIV_CYCLES, i.e. exactly N cycles high.
- hi/lo take the new result at E_N, the same edge busy falls; valid for reads in the cycle after E_N.
- hi/lo hold their old values throughout RUN.
- MTHI/MTLO: hi/lo updated at the accept edge; visible the next cycle.
- Back-to-back: a new start may be accepted at the edge after busy falls (zero idle cycles).
- Reset asserted mid-RUN: at that edge busy=0 and hi=lo=0, with no commit of the in-flight result; start in the same cycle as reset is ignored.
- Counter width is ceil(log2(max(MULT_CYCLES,DIV_CYCLES)+1)); no wrap is possible.

## Test plan
- Reset, then MULT rs=0xFFFFFFFE (−2), rt=3 → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
  - Change rs/rt mid-run → result unchanged.
- DIV rs=0xFFFFFFF9 (−7), rt=2 → busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Follow with DIVU 7/0 → hi/lo retain −7/2 results; busy still 10 cycles.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
  - start+MTLO issued during busy → ignored; lo unchanged.
- MTHI rs=0x12345678 then MTLO rs=0x9ABCDEF0 on consecutive cycles → hi/lo updated on each next cycle; busy never asserts.
- Start DIV, assert reset on cycle 4 of RUN → next cycle busy=0, hi=lo=0.
  - New MULT accepted on the following edge completes normally.
